// File: rtl/fifo_drain_serializer_pkg.sv
// Shared definitions for the FIFO drain serializer: FSM encoding and
// elaboration-time parameter helpers.
package fifo_drain_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // A word must split into a whole number of output beats.
    function automatic bit width_legal(input int width, input int out_width);
        return (out_width > 0) && (width >= out_width) && ((width % out_width) == 0);
    endfunction

    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/fifo_drain_serializer_ff.sv
// Enabled register with synchronous active-high reset to INIT.
module fifo_drain_serializer_ff #(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= INIT;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fifo_drain_serializer.sv
// Pops whole words from the FIFO head and emits them as narrow valid/ready
// beats, reloading on the last beat so a ready sink sees no bubbles.
module fifo_drain_serializer
    import fifo_drain_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 2,
    parameter int MSB_FIRST = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 fifo_pop,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
);

    localparam int BEATS   = WIDTH / OUT_WIDTH;
    localparam int BCNTWID = cnt_width(BEATS);

    if (!width_legal(WIDTH, OUT_WIDTH)) begin : g_bad_width
        $error("fifo_drain_serializer: WIDTH must be a multiple of OUT_WIDTH");
    end

    state_e               state_q, state_d;
    logic [BCNTWID-1:0]   beat_cnt_q, beat_cnt_d;
    logic [WIDTH-1:0]     shreg_q;
    logic [WIDTH-1:0]     shreg_shifted;
    logic [WIDTH-1:0]     shreg_d;
    logic                 xfer;
    logic                 load;
    logic                 shreg_en;

    assign xfer = out_valid & out_ready;
    // Head data is valid before the pop edge, so capture and pop coincide.
    assign load = !rst && !fifo_empty && ((state_q == ST_IDLE) || (xfer && out_last));
    assign fifo_pop = load;

    assign shreg_shifted = (MSB_FIRST != 0) ? (shreg_q << OUT_WIDTH) : (shreg_q >> OUT_WIDTH);
    assign shreg_d       = load ? fifo_data : shreg_shifted;
    assign shreg_en      = load | xfer;

    fifo_drain_serializer_ff #(
        .WIDTH (WIDTH),
        .INIT  ('0)
    ) u_shreg (
        .clk  (clk),
        .rst  (rst),
        .en_i (shreg_en),
        .d_i  (shreg_d),
        .q_o  (shreg_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        if (load) begin
            state_d    = ST_SHIFT;
            beat_cnt_d = '0;
        end else if (xfer) begin
            if (out_last) begin
                state_d = ST_IDLE;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        if (state_q == ST_SHIFT) begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_last  = (beat_cnt_q == BCNTWID'(BEATS - 1));
            out_data  = (MSB_FIRST != 0) ? shreg_q[WIDTH-1 -: OUT_WIDTH]
                                         : shreg_q[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Directed bench: a small FIFO model feeds an LSB-first and an MSB-first
// serializer sharing the same handshake inputs.
module tb_fifo_drain_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_pop, fifo_pop_m;
    logic       out_valid, out_valid_m;
    logic       out_ready;
    logic [1:0] out_data, out_data_m;
    logic       out_last, out_last_m;
    logic       busy, busy_m;

    int compared = 0;
    int mismatched = 0;
    int pop_cnt = 0;

    logic [7:0] mem [0:15];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;

    int exp_b4_lsb [4] = '{0, 1, 3, 2};
    int exp_b4_msb [4] = '{2, 3, 1, 0};
    int exp_b2b    [8] = '{3, 2, 1, 0, 0, 1, 2, 3};
    int exp_e4     [4] = '{0, 1, 2, 3};

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_data  = mem[rd_ptr[3:0]];

    fifo_drain_serializer #(.WIDTH(8), .OUT_WIDTH(2), .MSB_FIRST(0)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_pop(fifo_pop), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    fifo_drain_serializer #(.WIDTH(8), .OUT_WIDTH(2), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_pop(fifo_pop_m), .out_valid(out_valid_m), .out_ready(out_ready),
        .out_data(out_data_m), .out_last(out_last_m), .busy(busy_m)
    );

    // FIFO model plus continuous pop-safety checks
    always @(posedge clk) begin
        compared++;
        if (fifo_pop && fifo_empty) begin
            mismatched++;
            $display("FAIL pop_when_empty: pop=%0b empty=%0b (pop must be 0)", fifo_pop, fifo_empty);
        end
        compared++;
        if (fifo_pop_m !== fifo_pop) begin
            mismatched++;
            $display("FAIL pop_agree: msb_pop=%0b lsb_pop=%0b", fifo_pop_m, fifo_pop);
        end
        if (rst) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_pop) begin
            rd_ptr <= rd_ptr + 8'd1;
            pop_cnt++;
        end
    end

    task automatic push(input logic [7:0] w);
        mem[wr_ptr[3:0]] = w;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({out_valid, out_last, busy, out_data, fifo_pop} !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: valid=%0b last=%0b busy=%0b data=%0d pop=%0b required all 0",
                     out_valid, out_last, busy, out_data, fifo_pop);
        end
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if ({out_valid, busy, fifo_pop} !== 3'b0) begin
            mismatched++;
            $display("FAIL post_reset_idle: valid=%0b busy=%0b pop=%0b required 0", out_valid, busy, fifo_pop);
        end
    endtask

    task automatic test_single();
        int p0 = pop_cnt;
        push(8'hB4);
        #1;
        compared++;
        if (fifo_pop !== 1'b1) begin
            mismatched++;
            $display("FAIL single_pop: pop=%0b required 1", fifo_pop);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            compared++;
            if (out_valid !== 1'b1 || out_data !== 2'(exp_b4_lsb[i]) || out_last !== (i == 3)
                || fifo_pop !== 1'b0 || busy !== 1'b1) begin
                mismatched++;
                $display("FAIL single_beat%0d: valid=%0b data=%0d last=%0b pop=%0b busy=%0b required 1 %0d %0b 0 1",
                         i, out_valid, out_data, out_last, fifo_pop, busy, exp_b4_lsb[i], (i == 3));
            end
        end
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 2'd0 || pop_cnt - p0 != 1) begin
            mismatched++;
            $display("FAIL single_idle: valid=%0b busy=%0b data=%0d pops=%0d required 0 0 0 1",
                     out_valid, busy, out_data, pop_cnt - p0);
        end
    endtask

    task automatic test_back_to_back();
        push(8'h1B);
        push(8'hE4);
        #1;
        compared++;
        if (fifo_pop !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_first_pop: pop=%0b required 1", fifo_pop);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            compared++;
            if (out_valid !== 1'b1 || out_data !== 2'(exp_b2b[i]) || out_last !== (i == 3 || i == 7)
                || fifo_pop !== (i == 3)) begin
                mismatched++;
                $display("FAIL b2b_beat%0d: valid=%0b data=%0d last=%0b pop=%0b required 1 %0d %0b %0b",
                         i, out_valid, out_data, out_last, fifo_pop, exp_b2b[i], (i == 3 || i == 7), (i == 3));
            end
        end
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_idle: valid=%0b busy=%0b required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        push(8'hB4);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        push(8'h55);
        #1;
        compared++;
        if (out_data !== 2'd1 || fifo_pop !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_enter: data=%0d pop=%0b required 1 0", out_data, fifo_pop);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compared++;
            if (out_valid !== 1'b1 || out_data !== 2'd1 || out_last !== 1'b0 || fifo_pop !== 1'b0) begin
                mismatched++;
                $display("FAIL bp_hold%0d: valid=%0b data=%0d last=%0b pop=%0b required 1 1 0 0",
                         i, out_valid, out_data, out_last, fifo_pop);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (out_data !== 2'd3 || out_last !== 1'b0 || fifo_pop !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_resume_b2: data=%0d last=%0b pop=%0b required 3 0 0", out_data, out_last, fifo_pop);
        end
        @(negedge clk);
        compared++;
        if (out_data !== 2'd2 || out_last !== 1'b1 || fifo_pop !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_resume_b3: data=%0d last=%0b pop=%0b required 2 1 1", out_data, out_last, fifo_pop);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            compared++;
            if (out_valid !== 1'b1 || out_data !== 2'd1 || out_last !== (i == 3)) begin
                mismatched++;
                $display("FAIL bp_next_beat%0d: valid=%0b data=%0d last=%0b required 1 1 %0b",
                         i, out_valid, out_data, out_last, (i == 3));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_msb_first();
        push(8'hB4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            compared++;
            if (out_valid_m !== 1'b1 || out_data_m !== 2'(exp_b4_msb[i]) || out_last_m !== (i == 3)
                || busy_m !== 1'b1) begin
                mismatched++;
                $display("FAIL msb_beat%0d: valid=%0b data=%0d last=%0b busy=%0b required 1 %0d %0b 1",
                         i, out_valid_m, out_data_m, out_last_m, busy_m, exp_b4_msb[i], (i == 3));
            end
        end
        @(negedge clk);
        compared++;
        if (out_valid_m !== 1'b0 || busy_m !== 1'b0 || out_data_m !== 2'd0) begin
            mismatched++;
            $display("FAIL msb_idle: valid=%0b busy=%0b data=%0d required 0 0 0", out_valid_m, busy_m, out_data_m);
        end
    endtask

    task automatic test_empty_guard();
        int p0 = pop_cnt;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            compared++;
            if (fifo_pop !== 1'b0 || out_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL empty_cycle%0d: pop=%0b valid=%0b required 0 0", i, fifo_pop, out_valid);
            end
        end
        push(8'h55);
        #1;
        compared++;
        if (fifo_pop !== 1'b1 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL empty_push_pop: pop=%0b valid=%0b required 1 0", fifo_pop, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            compared++;
            if (out_valid !== 1'b1 || out_data !== 2'd1 || out_last !== (i == 3)) begin
                mismatched++;
                $display("FAIL empty_beat%0d: valid=%0b data=%0d last=%0b required 1 1 %0b",
                         i, out_valid, out_data, out_last, (i == 3));
            end
        end
        @(negedge clk);
        compared++;
        if (pop_cnt - p0 != 1 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL empty_popcount: pops=%0d valid=%0b required 1 0", pop_cnt - p0, out_valid);
        end
    endtask

    task automatic test_reset_mid_word();
        push(8'hB4);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (out_data !== 2'd3) begin
            mismatched++;
            $display("FAIL rmw_pre: data=%0d required 3", out_data);
        end
        rst = 1'b1;
        #1;
        compared++;
        if (fifo_pop !== 1'b0) begin
            mismatched++;
            $display("FAIL rmw_pop_in_rst: pop=%0b required 0", fifo_pop);
        end
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0 || fifo_pop !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rmw_after: valid=%0b pop=%0b busy=%0b required 0 0 0", out_valid, fifo_pop, busy);
        end
        push(8'h1B);
        #1;
        compared++;
        if (fifo_pop !== 1'b0) begin
            mismatched++;
            $display("FAIL rmw_pop_gated: pop=%0b required 0", fifo_pop);
        end
        @(negedge clk);
        rst = 1'b0;
        push(8'hE4);
        #1;
        compared++;
        if (fifo_pop !== 1'b1) begin
            mismatched++;
            $display("FAIL rmw_fresh_pop: pop=%0b required 1", fifo_pop);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            compared++;
            if (out_valid !== 1'b1 || out_data !== 2'(exp_e4[i]) || out_last !== (i == 3)) begin
                mismatched++;
                $display("FAIL rmw_beat%0d: valid=%0b data=%0d last=%0b required 1 %0d %0b",
                         i, out_valid, out_data, out_last, exp_e4[i], (i == 3));
            end
        end
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0 || fifo_empty !== 1'b1) begin
            mismatched++;
            $display("FAIL rmw_idle: valid=%0b empty=%0b required 0 1", out_valid, fifo_empty);
        end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_msb_first();
        test_empty_guard();
        test_reset_mid_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_drain_serializer.md
Name: fifo_drain_serializer

Overview:
Downstream consumer of the shift-register FIFO. Pops one WIDTH-bit word whenever the FIFO is non-empty and the block is free, then emits it as WIDTH/OUT_WIDTH narrow beats on a valid/ready output channel. Reloads back-to-back, so a continuously ready sink sees one beat per cycle with no bubble between words. Guarantees the FIFO's pop-side environment constraint: it never pops when the FIFO is empty.

Parameters:
WIDTH, 8, FIFO word width; must equal the FIFO's WIDTH.
OUT_WIDTH, 2, output beat width; WIDTH % OUT_WIDTH == 0, otherwise elaboration error.
MSB_FIRST, 0, 0 = emit least-significant beat first; 1 = emit most-significant beat first.
BEATS, WIDTH/OUT_WIDTH, beats per word (derived; do not override).
BCNTWID, $clog2(BEATS) (minimum 1), beat counter width (derived).

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high; shared with the FIFO
fifo_empty  input  1  FIFO empty flag
fifo_data  input  WIDTH  FIFO head entry (combinational data_out, valid while !fifo_empty)
fifo_pop  output  1  pop strobe to the FIFO; combinational
out_valid  output  1  beat valid
out_ready  input  1  sink ready
out_data  output  OUT_WIDTH  current beat
out_last  output  1  current beat is the final beat of its word
busy  output  1  a word is held (state SHIFT)

Behaviour:
- States: IDLE, SHIFT. Registers: state, shreg[WIDTH-1:0], beat_cnt[BCNTWID-1:0].
- Reset (rst=1 at a clock edge): state<=IDLE, shreg<=0, beat_cnt<=0. fifo_pop=0 whenever rst=1. Post-reset outputs: out_valid=0, out_last=0, busy=0, out_data=0.
- load = !rst & !fifo_empty & (state==IDLE | (out_valid & out_ready & out_last)). fifo_pop = load.
- On load: shreg<=fifo_data, beat_cnt<=0, state<=SHIFT. Data is captured in the same cycle as the pop, because the FIFO head is valid before the pop edge.
- Latency: word at FIFO head in IDLE -> first beat valid on the next cycle.
- SHIFT: out_valid=1, busy=1.
  - out_data = shreg[OUT_WIDTH-1:0] when MSB_FIRST=0; shreg[WIDTH-1:WIDTH-OUT_WIDTH] when MSB_FIRST=1.
  - out_last = (beat_cnt == BEATS-1).
- Handshake: beat transfers when out_valid & out_ready. While out_ready=0, out_data, out_last, shreg and beat_cnt hold stable. out_valid never drops without a transfer.
- Non-last transfer: shreg shifts by OUT_WIDTH toward the emitted end (zero fill); beat_cnt<=beat_cnt+1.
- Last transfer with fifo_empty=0: reload as in the load rule above; out_valid stays 1.
- Last transfer with fifo_empty=1: state<=IDLE.
- IDLE: out_valid=0, out_last=0, out_data=0, busy=0.
- BEATS==1: every beat is last; each transfer pops the next word.
- Reset mid-word: the held word is discarded and no beat completes. The FIFO resets on the same rst, so no pop is lost or duplicated.
- fifo_pop is never asserted when fifo_empty=1 and never twice for one word. Bench asserts both.

Decomposition:
- Shared package/include: state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1, and the parameter-legality check macro for WIDTH % OUT_WIDTH.
- One sub-module: the team's existing FF primitive (WIDTH, INIT=0, sync rst, en) holds shreg.
  - en = load | (out_valid & out_ready).
  - D = load ? fifo_data : shifted shreg.
- state and beat_cnt live in plain always blocks.

Test Plan:
- Single word: WIDTH=8, OUT_WIDTH=2, MSB_FIRST=0, out_ready=1; FIFO holds 8'hB4 -> fifo_pop for exactly 1 cycle; beats 0,1,3,2 on consecutive cycles; out_last on the 4th beat; then IDLE, busy=0.
- Back-to-back: FIFO holds 8'h1B, 8'hE4, out_ready=1 -> 8 consecutive valid beats 3,2,1,0,0,1,2,3; second pop coincides with the first word's last beat; no bubble.
- Backpressure: out_ready=0 for 5 cycles mid-word -> out_data and out_last frozen, no pop. Release -> the remaining beats complete in order.
- MSB_FIRST=1, word 8'hB4 -> beats 2,3,1,0.
- Empty guard: FIFO empty for 20 cycles, out_ready=1 -> fifo_pop=0, out_valid=0 throughout. Push 8'h55 -> pop one cycle later; 4 beats of 1.
- Reset mid-word: assert rst after beat 2 of 8'hB4 -> next cycle out_valid=0, fifo_pop=0. After deassertion, fresh pushes serialize correctly from beat 0.
